// File: rtl/tick_frame_pkg.sv
// ----------------------------------------------------------------------------
// tick_frame_pkg : shared state encoding, default header and sizing helper
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package tick_frame_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HDR     = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;
  localparam logic [1:0] ST_CSUM    = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    HDR     = ST_HDR,
    PAYLOAD = ST_PAYLOAD,
    CSUM    = ST_CSUM
  } state_t;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

  function automatic int frame_bytes(input int data_w);
    return data_w / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter : W-bit up counter that sticks at all-ones instead of wrapping
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/tick_frame_sender.sv
// ----------------------------------------------------------------------------
// tick_frame_sender : snapshots a sample on each accepted tick and streams it
// as header + payload bytes (+ XOR checksum when FRAME_CHECKSUM_EN is defined)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tick_frame_sender
  import tick_frame_pkg::*;
#(
  parameter int         DATA_W      = 32,
  parameter logic [7:0] HEADER_BYTE = DEFAULT_HEADER,
  parameter int         OVR_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic [DATA_W-1:0] sample_in,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [OVR_W-1:0]  overrun_cnt,
  output logic              frame_done
);

  localparam int BYTES = frame_bytes(DATA_W);
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [IDX_W-1:0]  idx;
  logic              xfer;
  logic              drop;

  assign xfer = out_valid && out_ready;
  // Any tick outside IDLE is lost, including the one landing on the last transfer.
  assign drop = tick && (state != IDLE);

`ifdef FRAME_CHECKSUM_EN
  logic [7:0] csum;
`endif

  sat_counter #(.W(OVR_W)) u_overrun (
    .clk   (clk),
    .reset (reset),
    .inc   (drop),
    .clear (1'b0),
    .count (overrun_cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      idx        <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) begin
            shreg     <= sample_in;
            idx       <= '0;
            state     <= HDR;
            out_valid <= 1'b1;
            out_data  <= HEADER_BYTE;
            busy      <= 1'b1;
`ifdef FRAME_CHECKSUM_EN
            csum      <= HEADER_BYTE;
`endif
          end
        end
        HDR: begin
          if (xfer) begin
            state    <= PAYLOAD;
            out_data <= shreg[DATA_W-1 -: 8];
            shreg    <= shreg << 8;
          end
        end
        PAYLOAD: begin
          if (xfer) begin
`ifdef FRAME_CHECKSUM_EN
            csum <= csum ^ out_data;
`endif
            if (idx == LAST_IDX) begin
`ifdef FRAME_CHECKSUM_EN
              state    <= CSUM;
              out_data <= csum ^ out_data;
`else
              state      <= IDLE;
              out_valid  <= 1'b0;
              busy       <= 1'b0;
              frame_done <= 1'b1;
`endif
            end else begin
              idx      <= idx + IDX_W'(1);
              out_data <= shreg[DATA_W-1 -: 8];
              shreg    <= shreg << 8;
            end
          end
        end
`ifdef FRAME_CHECKSUM_EN
        CSUM: begin
          if (xfer) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
`endif
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tick_frame_sender.sv
// ----------------------------------------------------------------------------
// tb_tick_frame_sender : directed table + sequence bench for tick_frame_sender
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_tick_frame_sender;

  localparam int DATA_W = 32;
  localparam int OVR_W  = 8;
`ifdef FRAME_CHECKSUM_EN
  localparam int NB = 6;
`else
  localparam int NB = 5;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              tick;
  logic [DATA_W-1:0] sample_in;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic [OVR_W-1:0]  overrun_cnt;
  logic              frame_done;

  int checks = 0;
  int errors = 0;

  tick_frame_sender #(.DATA_W(DATA_W), .HEADER_BYTE(8'hA5), .OVR_W(OVR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .sample_in   (sample_in),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .overrun_cnt (overrun_cnt),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        tick;
    logic [31:0] sample;
    logic        ready;
    logic        ev;
    logic [7:0]  ed;
    logic        eb;
    logic        edn;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int t, input logic [31:0] s, input int r,
                              input int v, input logic [7:0] d, input int b, input int dn);
    vec_t x;
    x.tick   = 1'(t);
    x.sample = s;
    x.ready  = 1'(r);
    x.ev     = 1'(v);
    x.ed     = d;
    x.eb     = 1'(b);
    x.edn    = 1'(dn);
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_bytes [6];
  logic [7:0] got[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nx, nd;
    bit seen;
    logic [31:0] act;

    exp_bytes = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'hAD};

    // Basic frame, ready held high
    vecs.push_back(mk(1, 32'h12345678, 1, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 32'h12345678, 1, 1, 8'hA5, 1, 0));
    vecs.push_back(mk(0, 32'h12345678, 1, 1, 8'h12, 1, 0));
    vecs.push_back(mk(0, 32'h12345678, 1, 1, 8'h34, 1, 0));
    vecs.push_back(mk(0, 32'h12345678, 1, 1, 8'h56, 1, 0));
    vecs.push_back(mk(0, 32'h12345678, 1, 1, 8'h78, 1, 0));
`ifdef FRAME_CHECKSUM_EN
    vecs.push_back(mk(0, 32'h12345678, 1, 1, 8'hAD, 1, 0));
`endif
    vecs.push_back(mk(0, 32'h12345678, 1, 0, 8'h00, 0, 1));
    vecs.push_back(mk(0, 32'h12345678, 1, 0, 8'h00, 0, 0));
    // Backpressure: byte 0x34 stalled for three cycles
    vecs.push_back(mk(1, 32'h12345678, 1, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 32'h12345678, 1, 1, 8'hA5, 1, 0));
    vecs.push_back(mk(0, 32'h12345678, 1, 1, 8'h12, 1, 0));
    vecs.push_back(mk(0, 32'h12345678, 0, 1, 8'h34, 1, 0));
    vecs.push_back(mk(0, 32'h12345678, 0, 1, 8'h34, 1, 0));
    vecs.push_back(mk(0, 32'h12345678, 0, 1, 8'h34, 1, 0));
    vecs.push_back(mk(0, 32'h12345678, 1, 1, 8'h34, 1, 0));
    vecs.push_back(mk(0, 32'h12345678, 1, 1, 8'h56, 1, 0));
    vecs.push_back(mk(0, 32'h12345678, 1, 1, 8'h78, 1, 0));
`ifdef FRAME_CHECKSUM_EN
    vecs.push_back(mk(0, 32'h12345678, 1, 1, 8'hAD, 1, 0));
`endif
    vecs.push_back(mk(0, 32'h12345678, 1, 0, 8'h00, 0, 1));
    vecs.push_back(mk(0, 32'h12345678, 1, 0, 8'h00, 0, 0));

    reset     = 1'b1;
    tick      = 1'b0;
    sample_in = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset frame_done", 32'(frame_done), 32'd0);
    check("reset overrun_cnt", 32'(overrun_cnt), 32'd0);
    check("reset out_data", 32'(out_data), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      next_cycle();
      tick      = vecs[i].tick;
      sample_in = vecs[i].sample;
      out_ready = vecs[i].ready;
      @(negedge clk);
      check($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(vecs[i].ev));
      check($sformatf("row%0d busy", i), 32'(busy), 32'(vecs[i].eb));
      check($sformatf("row%0d frame_done", i), 32'(frame_done), 32'(vecs[i].edn));
      if (vecs[i].ev)
        check($sformatf("row%0d out_data", i), 32'(out_data), 32'(vecs[i].ed));
    end
    check("tables overrun_cnt", 32'(overrun_cnt), 32'd0);

    // Overrun: ticks 2 cycles after start and on the final transfer are dropped
    nx = 0;
    nd = 0;
    for (int k = 0; k < 14; k++) begin
      next_cycle();
      tick      = (k == 0 || k == 2 || k == NB);
      sample_in = 32'h12345678;
      out_ready = 1'b1;
      @(negedge clk);
      if (out_valid && out_ready) nx++;
      if (frame_done) nd++;
    end
    check("overrun cnt", 32'(overrun_cnt), 32'd2);
    check("overrun bytes sent", 32'(nx), 32'(NB));
    check("overrun frames done", 32'(nd), 32'd1);

    // Saturation: start a frame with ready low, then hammer ticks
    next_cycle();
    tick = 1'b1;
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) next_cycle();
    next_cycle();
    tick = 1'b0;
    @(negedge clk);
    check("sat partial cnt", 32'(overrun_cnt), 32'd12);
    check("sat start valid", 32'(out_valid), 32'd1);
    check("sat start data", 32'(out_data), 32'hA5);
    tick = 1'b1;
    for (int k = 0; k < 290; k++) next_cycle();
    tick = 1'b0;
    next_cycle();
    @(negedge clk);
    check("sat full cnt", 32'(overrun_cnt), 32'hFF);
    check("sat hold data", 32'(out_data), 32'hA5);

    // Reset mid-PAYLOAD
    next_cycle();
    out_ready = 1'b1;
    next_cycle();
    @(negedge clk);
    check("pre-reset data", 32'(out_data), 32'h12);
    check("pre-reset busy", 32'(busy), 32'd1);
    next_cycle();
    reset = 1'b1;
    #1;
    check("async reset valid", 32'(out_valid), 32'd0);
    check("async reset busy", 32'(busy), 32'd0);
    check("async reset overrun", 32'(overrun_cnt), 32'd0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("post-reset valid", 32'(out_valid), 32'd0);
    check("post-reset busy", 32'(busy), 32'd0);

    // Fresh frame; sample changes right after the accepted tick
    next_cycle();
    tick      = 1'b1;
    sample_in = 32'h12345678;
    out_ready = 1'b1;
    next_cycle();
    tick      = 1'b0;
    sample_in = 32'hDEADBEEF;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (out_valid && out_ready) got.push_back(out_data);
      if (frame_done) seen = 1'b1;
      next_cycle();
    end
    check("fresh frame_done seen", 32'(seen), 32'd1);
    check("fresh byte count", 32'(got.size()), 32'(NB));
    for (int i = 0; i < NB; i++) begin
      act = (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF;
      check($sformatf("fresh byte%0d", i), act, 32'(exp_bytes[i]));
    end
    check("fresh overrun", 32'(overrun_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
